mesh_serial_router: RTL and testbench

MESH_SERIAL_ROUTER -- requirements
Module: mesh_serial_router

---
 rtl/mesh_serial_router_pkg.sv | 27 ++
 rtl/mesh_serial_router_rr_arbiter.sv | 27 ++
 rtl/mesh_serial_router.sv | 173 +++++++++++++++++
 tb/tb_mesh_serial_router.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mesh_serial_router_pkg.sv
// Shared definitions for the serial mesh router: port indices, FSM encoding and header sizing.
package mesh_serial_router_pkg;

  localparam int NPORTS = 5;

  localparam logic [2:0] PORT_N     = 3'd0;
  localparam logic [2:0] PORT_E     = 3'd1;
  localparam logic [2:0] PORT_S     = 3'd2;
  localparam logic [2:0] PORT_W     = 3'd3;
  localparam logic [2:0] PORT_LOCAL = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_RX_HDR,
    ST_RX_PAY,
    ST_ROUTE,
    ST_TX_REQ,
    ST_TX
  } state_e;

  // Header carries dest x, dest y and the payload length in bytes.
  function automatic int hdr_bits(input int cw, input int lw);
    return 2 * cw + lw;
  endfunction

endpackage

// File: rtl/mesh_serial_router_rr_arbiter.sv
// Round-robin arbiter: grants the lowest requesting port index at or after the pointer.
module mesh_serial_router_rr_arbiter
  import mesh_serial_router_pkg::*;
(
  input  logic [NPORTS-1:0] req_i,
  input  logic [2:0]        ptr_i,
  output logic [NPORTS-1:0] gnt_o,
  output logic              valid_o
);

  logic [2:0] idx;

  // NOTE: every combinational output gets a default before the loop so no latch is inferred.
  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int k = 0; k < NPORTS; k++) begin
      idx = 3'((int'(ptr_i) + k) % NPORTS);
      if (!valid_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mesh_serial_router.sv
// Store-and-forward serial mesh router: one packet buffer, XY routing, round-robin input grant.
module mesh_serial_router
  import mesh_serial_router_pkg::*;
#(
  parameter int X_COOR = 0,
  parameter int Y_COOR = 0,
  parameter int CW     = 2,
  parameter int LW     = 2,
  parameter int MAXB   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NPORTS-1:0] in_req,
  output logic [NPORTS-1:0] in_ack,
  input  logic [NPORTS-1:0] in_data,
  output logic [NPORTS-1:0] out_req,
  input  logic [NPORTS-1:0] out_ack,
  output logic [NPORTS-1:0] out_data,
  output logic              busy,
  output logic              drop
);

  localparam int HB   = hdr_bits(CW, LW);
  localparam int PW   = HB + 8 * MAXB;
  localparam int CNTW = $clog2(PW + 1);

  state_e          state_q, state_d;
  logic [2:0]      rr_q, rr_d, w_q, w_d, o_q, o_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [LW-1:0]   byte_q, byte_d;
  logic [2:0]      bit_q, bit_d;
  logic [PW-1:0]   pkt_q, pkt_d;

  logic [NPORTS-1:0] gnt;
  logic              arb_valid;
  logic [2:0]        gnt_idx, route;
  logic [CW-1:0]     dst_x, dst_y;
  logic [LW-1:0]     len_f, len_w;
  logic [PW-1:0]     pkt_w;
  logic              in_bit, tx_bit, reject;
  int                rx_idx, tot_bits;

  mesh_serial_router_rr_arbiter u_arb (
    .req_i   (in_req),
    .ptr_i   (rr_q),
    .gnt_o   (gnt),
    .valid_o (arb_valid)
  );

  assign dst_x = pkt_q[CW-1:0];
  assign dst_y = pkt_q[2*CW-1:CW];
  assign len_f = pkt_q[HB-1:2*CW];

  always_comb begin
    gnt_idx = '0;
    for (int k = 0; k < NPORTS; k++) begin
      if (gnt[k]) gnt_idx = 3'(k);
    end

    if (int'(dst_x) > X_COOR)      route = PORT_E;
    else if (int'(dst_x) < X_COOR) route = PORT_W;
    else if (int'(dst_y) > Y_COOR) route = PORT_N;
    else if (int'(dst_y) < Y_COOR) route = PORT_S;
    else                           route = PORT_LOCAL;

    reject   = (int'(len_f) > MAXB) || ((route != PORT_LOCAL) && (route == w_q));
    tot_bits = HB + 8 * int'(len_f);
    tx_bit   = |(pkt_q & (PW'(1) << cnt_q));

    // Bits land at their packet offset; payload beyond the buffer is consumed but not stored.
    in_bit = in_data[w_q];
    rx_idx = (state_q == ST_RX_HDR) ? int'(cnt_q) : HB + 8 * int'(byte_q) + int'(bit_q);
    pkt_w  = (pkt_q & ~(PW'(1) << rx_idx)) | (PW'(in_bit) << rx_idx);
    len_w  = pkt_w[HB-1:2*CW];
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    w_d      = w_q;
    o_d      = o_q;
    cnt_d    = cnt_q;
    byte_d   = byte_q;
    bit_d    = bit_q;
    pkt_d    = pkt_q;
    in_ack   = '0;
    out_req  = '0;
    out_data = '0;
    drop     = 1'b0;
    busy     = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          w_d     = gnt_idx;
          rr_d    = (gnt_idx == 3'(NPORTS - 1)) ? 3'd0 : gnt_idx + 3'd1;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        in_ack[w_q] = 1'b1;
        cnt_d       = '0;
        state_d     = ST_RX_HDR;
      end
      ST_RX_HDR: begin
        pkt_d = pkt_w;
        if (cnt_q == CNTW'(HB - 1)) begin
          cnt_d   = '0;
          byte_d  = '0;
          bit_d   = '0;
          state_d = (len_w == '0) ? ST_ROUTE : ST_RX_PAY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RX_PAY: begin
        if (int'(byte_q) < MAXB) pkt_d = pkt_w;
        if (bit_q == 3'd7) begin
          bit_d = '0;
          if (int'(byte_q) == int'(len_f) - 1) state_d = ST_ROUTE;
          else                                 byte_d  = byte_q + 1'b1;
        end else begin
          bit_d = bit_q + 3'd1;
        end
      end
      ST_ROUTE: begin
        cnt_d = '0;
        if (reject) begin
          drop    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          o_d     = route;
          state_d = ST_TX_REQ;
        end
      end
      ST_TX_REQ: begin
        out_req[o_q] = 1'b1;
        if (out_ack[o_q]) state_d = ST_TX;
      end
      ST_TX: begin
        out_data[o_q] = tx_bit;
        if (int'(cnt_q) == tot_bits - 1) state_d = ST_IDLE;
        else                             cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the packet buffer is reset along with the control state so a fresh packet never sees stale bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      w_q     <= '0;
      o_q     <= '0;
      cnt_q   <= '0;
      byte_q  <= '0;
      bit_q   <= '0;
      pkt_q   <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
      state_q <= state_d;
      rr_q    <= rr_d;
      w_q     <= w_d;
      o_q     <= o_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      pkt_q   <= pkt_d;
    end
  end

endmodule

// File: tb/tb_mesh_serial_router.sv
// Scoreboard bench for mesh_serial_router: neighbour senders feed packets, a monitor checks deliveries and drops.
module tb_mesh_serial_router;

  localparam int CW = 2, LW = 2, MAXB = 2, XC = 1, YC = 1;
  localparam int HB = 2 * CW + LW;
  localparam int P_N = 0, P_E = 1, P_S = 2, P_W = 3, P_L = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] in_req = '0, in_data = '0, out_ack = '0;
  logic [4:0] in_ack, out_req, out_data;
  logic       busy, drop;

  mesh_serial_router #(.X_COOR(XC), .Y_COOR(YC), .CW(CW), .LW(LW), .MAXB(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_req(in_req), .in_ack(in_ack), .in_data(in_data),
    .out_req(out_req), .out_ack(out_ack), .out_data(out_data),
    .busy(busy), .drop(drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_drop;
    int          port;
    logic [63:0] bits;
    int          nbits;
    int          ev_cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, errors = 0;
  bit          mon_en = 1'b0;
  int          px[5], py[5], plen[5];
  logic [23:0] pbytes[5];
  logic [4:0]  pending = '0;
  int          model_rr = 0;
  logic [63:0] last_stream;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // XY routing as stated: resolve column first, then row, else deliver locally.
  function automatic int route_of(input int x, input int y);
    if (x > XC) return P_E;
    if (x < XC) return P_W;
    if (y > YC) return P_N;
    if (y < YC) return P_S;
    return P_L;
  endfunction

  task automatic add_req(input int p, input int x, input int y, input int len, input logic [23:0] b);
    px[p] = x; py[p] = y; plen[p] = len; pbytes[p] = b;
    pending[p] = 1'b1;
  endtask

  // Present all pending requests, expect the round-robin winner, then stream its packet.
  task automatic serve();
    int w, nb, dest;
    bit got;
    logic [63:0] s;
    exp_t e;
    in_req = pending;
    w = -1;
    for (int k = 0; k < 5; k++)
      if (w < 0 && pending[(model_rr + k) % 5]) w = (model_rr + k) % 5;
    model_rr = (w + 1) % 5;
    got = 1'b0;
    for (int t = 0; t < 400 && !got; t++) begin
      @(negedge clk);
      if (in_ack != '0) got = 1'b1;
    end
    if (!got) begin
      check("grant_timeout", 64'd0, 64'd1);
      finish_sim();
    end
    check("grant_port", 64'(in_ack), 64'(1) << w);
    check("busy_in_grant", 64'(busy), 64'd1);
    nb = HB + 8 * plen[w];
    s = 64'(px[w]) | (64'(py[w]) << CW) | (64'(plen[w]) << (2 * CW)) | (64'(pbytes[w]) << HB);
    s = s & ((64'(1) << nb) - 64'd1);
    last_stream = s;
    dest = route_of(px[w], py[w]);
    e.is_drop = (plen[w] > MAXB) || (dest == w && dest != P_L);
    e.port    = dest;
    e.bits    = s;
    e.nbits   = nb;
    e.ev_cyc  = cyc + nb + (e.is_drop ? 1 : 2);
    if (mon_en) sb.push_back(e);
    pending[w] = 1'b0;
    in_req[w]  = 1'b0;
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      if (i == 0) check("ack_one_cycle", 64'(in_ack), 64'd0);
      in_data[w] = s[i];
    end
    @(negedge clk);
    in_data = '0;
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && (sb.size() != 0 || busy); t++) @(negedge clk);
    check("sb_drain", 64'(sb.size()), 64'd0);
  endtask

  exp_t        me;
  int          stall;
  bit          bad;
  logic [63:0] got_s;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && mon_en) begin
        if (drop) begin
          if (sb.size() == 0) check("unexpected_drop", 64'd1, 64'd0);
          else begin
            me = sb.pop_front();
            check("drop_expected", 64'(me.is_drop), 64'd1);
            check("drop_cycle", 64'(cyc), 64'(me.ev_cyc));
            check("drop_no_out_req", 64'(out_req), 64'd0);
          end
        end else if (out_req != '0) begin
          if (sb.size() == 0) check("unexpected_out_req", 64'(out_req), 64'd0);
          else begin
            me = sb.pop_front();
            check("deliver_expected", 64'(me.is_drop), 64'd0);
            check("out_req_port", 64'(out_req), 64'(1) << me.port);
            check("out_req_cycle", 64'(cyc), 64'(me.ev_cyc));
            stall = $urandom_range(0, 3);
            bad = 1'b0;
            repeat (stall) begin
              @(negedge clk);
              if (64'(out_req) != (64'(1) << me.port)) bad = 1'b1;
            end
            out_ack[me.port] = 1'b1;
            @(negedge clk);
            out_ack = '0;
            check("out_req_release", 64'(out_req), 64'd0);
            got_s = '0;
            for (int i = 0; i < me.nbits; i++) begin
              if (i > 0) @(negedge clk);
              got_s[i] = out_data[me.port];
              if ((64'(out_data) & ~(64'(1) << me.port)) != 0 || out_req != '0) bad = 1'b1;
            end
            check("tx_stream", got_s, me.bits);
            check("tx_quiet_lanes", 64'(bad), 64'd0);
          end
        end
      end
    end
  end

  initial begin
    bit got;
    int m;
    #1 rst_n = 1'b0;
    #2;
    check("rst_in_ack", 64'(in_ack), 64'd0);
    check("rst_out_req", 64'(out_req), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_drop", 64'(drop), 64'd0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // N, E, S requesting together from rr=0: served N, E, S in turn.
    add_req(P_N, 1, 1, 0, 24'h0);
    add_req(P_E, 1, 1, 1, 24'h3C);
    add_req(P_S, 1, 1, 2, 24'hBEEF);
    serve(); serve(); serve();

    // West to east, one byte 0xA5: out_req 17 cycles after the arbitration cycle.
    add_req(P_W, 2, 1, 1, 24'hA5);
    serve();

    // Oversized payload from LOCAL is consumed then dropped.
    add_req(P_L, 2, 1, 3, 24'h123456);
    serve();

    // U-turn from east is dropped; a local destination from east is delivered.
    add_req(P_E, 2, 1, 1, 24'h77);
    serve();
    add_req(P_E, 1, 1, 2, 24'hC3E1);
    serve();
    drain();

    repeat (40) begin
      m = $urandom_range(1, 31);
      for (int p = 0; p < 5; p++)
        if (m[p] && !pending[p])
          add_req(p, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 24'($urandom));
      serve();
    end
    while (pending != '0) serve();
    drain();

    // Reset in the middle of transmitting bit 4 after a stalled out_ack.
    mon_en = 1'b0;
    add_req(P_W, 2, 1, 2, 24'($urandom));
    serve();
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clk);
      if (out_req != '0) got = 1'b1;
    end
    check("rstcase_out_req", 64'(out_req), 64'(1) << P_E);
    repeat (3) @(negedge clk);
    out_ack[P_E] = 1'b1;
    @(negedge clk);
    out_ack = '0;
    repeat (4) @(negedge clk);
    check("rstcase_bit4", 64'(out_data), 64'(last_stream[4]) << P_E);
    #2 rst_n = 1'b0;
    #1;
    check("rstcase_out_data", 64'(out_data), 64'd0);
    check("rstcase_out_req0", 64'(out_req), 64'd0);
    check("rstcase_in_ack", 64'(in_ack), 64'd0);
    check("rstcase_busy", 64'(busy), 64'd0);
    check("rstcase_drop", 64'(drop), 64'd0);
    in_req = '0; in_data = '0; pending = '0; model_rr = 0;
    repeat (3) begin
      @(negedge clk);
      check("rstcase_no_drop", 64'(drop), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 64'({busy, drop}), 64'd0);

    // First grant after reset restarts round-robin at port 0: E beats LOCAL.
    mon_en = 1'b1;
    add_req(P_L, 2, 1, 0, 24'h0);
    add_req(P_E, 1, 1, 1, 24'h5A);
    serve(); serve();
    drain();
    finish_sim();
  end

endmodule
